// File: rtl/fp_conv_pkg.sv
// -----------------------------------------------------------------------------
// fp_conv_pkg
// Shared types and constants for the FP16/BF16 -> FP32 widening converter.
//   fmt_e      : operand format code carried through the pipeline
//   cls_e      : per-lane source classification computed in stage 1
//   s1_lane_t  : per-lane stage-1 register contents
//   decode_fmt : maps the raw 2-bit format code (reserved 11 -> pass-through)
// -----------------------------------------------------------------------------
package fp_conv_pkg;

  typedef enum logic [1:0] {
    FMT_PASS = 2'b00,
    FMT_FP16 = 2'b01,
    FMT_BF16 = 2'b10
  } fmt_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_e;

  localparam logic [7:0] FP16_BIAS_ADJ = 8'd112;  // 127 - 15
  localparam int         FP32_QNAN_BIT = 22;
  localparam logic [4:0] FP16_EXP_MAX  = 5'h1F;
  localparam logic [7:0] FP32_EXP_MAX  = 8'hFF;

  typedef struct packed {
    logic       sign;
    cls_e       cls;
    logic [4:0] exp;
    logic [9:0] mant;
    logic [3:0] shift;  // 10 - index of leading one in mant
  } s1_lane_t;

  function automatic fmt_e decode_fmt(input logic [1:0] code);
    case (code)
      2'b01:   return FMT_FP16;
      2'b10:   return FMT_BF16;
      default: return FMT_PASS;  // 11 is reserved and behaves as pass-through
    endcase
  endfunction

endpackage

// File: rtl/fp_lzc10.sv
// -----------------------------------------------------------------------------
// fp_lzc10
// Combinational leading-zero counter for a 10-bit FP16 mantissa.
//   mant  : subnormal mantissa (nonzero in normal use)
//   shift : leading zeros + 1 (1..10), i.e. the left shift that moves the
//           leading one out of the 10-bit field into the implicit position.
//           An all-zero mantissa returns 10; that value is never consumed.
// -----------------------------------------------------------------------------
module fp_lzc10 (
  input  logic [9:0] mant,
  output logic [3:0] shift
);

  // NOTE: combinational logic uses blocking assignments with a default first,
  // so every path assigns the output and no latch is inferred.
  always_comb begin
    shift = 4'd10;
    // Ascending scan: the highest set bit is the last to write.
    for (int i = 0; i < 10; i++) begin
      if (mant[i]) shift = 4'(10 - i);
    end
  end

endmodule

// File: rtl/fp16_to_fp32_pipe.sv
// -----------------------------------------------------------------------------
// fp16_to_fp32_pipe
// Multi-lane, 2-stage pipelined widening converter (FP16/BF16 -> FP32, or
// pass-through) with valid/ready flow control on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_ready = !s1_valid || adv
//   in_fmt              : 00 pass, 01 FP16, 10 BF16, 11 pass
//   in_data             : PARM_LANES packed lanes of PARM_XLEN bits
//   out_valid/out_ready : output handshake; outputs hold while stalled
//   out_data            : converted lanes, same packing as in_data
//   out_nan/inf/sub     : per-lane source class flags
// Stage 1 registers classification + leading-zero count, stage 2 registers
// the assembled FP32 words.
// -----------------------------------------------------------------------------
module fp16_to_fp32_pipe
  import fp_conv_pkg::*;
#(
  parameter int PARM_XLEN  = 32,
  parameter int PARM_LANES = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      in_fmt,
  input  logic [PARM_LANES*PARM_XLEN-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PARM_LANES*PARM_XLEN-1:0] out_data,
  output logic [PARM_LANES-1:0]           out_nan,
  output logic [PARM_LANES-1:0]           out_inf,
  output logic [PARM_LANES-1:0]           out_sub
);

  localparam int W = PARM_LANES * PARM_XLEN;

  logic                  s1_valid_q, s1_valid_d;
  fmt_e                  s1_fmt_q, s1_fmt_d;
  s1_lane_t [PARM_LANES-1:0] s1_lane_q, s1_lane_d;
  logic [W-1:0]          s1_data_q, s1_data_d;

  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          out_data_q, out_data_d;
  logic [PARM_LANES-1:0] out_nan_q, out_nan_d;
  logic [PARM_LANES-1:0] out_inf_q, out_inf_d;
  logic [PARM_LANES-1:0] out_sub_q, out_sub_d;

  logic [3:0]            lzc_shift [PARM_LANES];
  logic                  adv, in_fire, s1_adv;

  for (genvar g = 0; g < PARM_LANES; g++) begin : g_lzc
    fp_lzc10 u_lzc (
      .mant  (in_data[g*PARM_XLEN +: 10]),
      .shift (lzc_shift[g])
    );
  end

  // Flow control: S2 can take new data when empty or being drained.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || adv;
  assign in_fire  = in_valid && in_ready;
  assign s1_adv   = s1_valid_q && adv;

  // Stage 1: classify each lane in the format it is tagged with.
  always_comb begin
    logic [15:0] h;
    s1_valid_d = in_fire || (s1_valid_q && !adv);
    s1_fmt_d   = s1_fmt_q;
    s1_lane_d  = s1_lane_q;
    s1_data_d  = s1_data_q;
    h          = '0;
    if (in_fire) begin
      s1_fmt_d  = decode_fmt(in_fmt);
      s1_data_d = in_data;
      for (int k = 0; k < PARM_LANES; k++) begin
        h = in_data[k*PARM_XLEN +: 16];
        s1_lane_d[k].sign  = h[15];
        s1_lane_d[k].exp   = h[14:10];
        s1_lane_d[k].mant  = h[9:0];
        s1_lane_d[k].shift = lzc_shift[k];
        s1_lane_d[k].cls   = CLS_NORM;
        if (s1_fmt_d == FMT_FP16) begin
          if (h[14:10] == 5'd0)
            s1_lane_d[k].cls = (h[9:0] == 10'd0) ? CLS_ZERO : CLS_SUB;
          else if (h[14:10] == FP16_EXP_MAX)
            s1_lane_d[k].cls = (h[9:0] == 10'd0) ? CLS_INF : CLS_NAN;
        end else if (s1_fmt_d == FMT_BF16) begin
          if (h[14:7] == FP32_EXP_MAX)
            s1_lane_d[k].cls = (h[6:0] == 7'd0) ? CLS_INF : CLS_NAN;
        end
      end
    end
  end

  // Stage 2: assemble FP32 words from the stage-1 classification.
  always_comb begin
    logic [PARM_XLEN-1:0] lane_raw, lane_res;
    logic [31:0]          res32;
    logic [19:0]          mant_wide;
    s1_lane_t             ln;
    out_valid_d = adv ? s1_valid_q : out_valid_q;
    out_data_d  = out_data_q;
    out_nan_d   = out_nan_q;
    out_inf_d   = out_inf_q;
    out_sub_d   = out_sub_q;
    lane_raw    = '0;
    lane_res    = '0;
    res32       = '0;
    mant_wide   = '0;
    ln          = '0;
    if (s1_adv) begin
      for (int k = 0; k < PARM_LANES; k++) begin
        lane_raw  = s1_data_q[k*PARM_XLEN +: PARM_XLEN];
        ln        = s1_lane_q[k];
        mant_wide = {10'd0, ln.mant} << ln.shift;
        res32     = '0;
        case (ln.cls)
          CLS_ZERO: res32 = {ln.sign, 31'd0};
          CLS_SUB:  res32 = {ln.sign, 8'd113 - {4'd0, ln.shift}, mant_wide[9:0], 13'd0};
          CLS_INF:  res32 = {ln.sign, FP32_EXP_MAX, 23'd0};
          CLS_NAN:  res32 = {ln.sign, FP32_EXP_MAX, 1'b1, ln.mant[8:0], 13'd0};
          default:  res32 = {ln.sign, {3'd0, ln.exp} + FP16_BIAS_ADJ, ln.mant, 13'd0};
        endcase
        if (s1_fmt_q == FMT_BF16) begin
          res32 = {lane_raw[15:0], 16'd0};
          if (ln.cls == CLS_NAN) res32[FP32_QNAN_BIT] = 1'b1;
        end
        lane_res       = '0;
        lane_res[31:0] = res32;
        if (s1_fmt_q == FMT_PASS) lane_res = lane_raw;
        out_data_d[k*PARM_XLEN +: PARM_XLEN] = lane_res;
        out_nan_d[k] = (s1_fmt_q != FMT_PASS) && (ln.cls == CLS_NAN);
        out_inf_d[k] = (s1_fmt_q != FMT_PASS) && (ln.cls == CLS_INF);
        out_sub_d[k] = (s1_fmt_q == FMT_FP16) && (ln.cls == CLS_SUB);
      end
    end
  end

  // NOTE: the datapath registers are reset alongside the valids so the
  // outputs read as zero out of reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= FMT_PASS;
      s1_lane_q   <= '0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nan_q   <= '0;
      out_inf_q   <= '0;
      out_sub_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_lane_q   <= s1_lane_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nan_q   <= out_nan_d;
      out_inf_q   <= out_inf_d;
      out_sub_q   <= out_sub_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nan   = out_nan_q;
  assign out_inf   = out_inf_q;
  assign out_sub   = out_sub_q;

endmodule

// File: tb/tb_fp16_to_fp32_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp16_to_fp32_pipe
// Scoreboard bench: expected lanes are computed by a behavioural model when an
// input transfer happens and compared in order when an output transfer happens.
// -----------------------------------------------------------------------------
module tb_fp16_to_fp32_pipe;

  localparam int XLEN  = 32;
  localparam int LANES = 4;
  localparam int W     = XLEN * LANES;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [1:0]       in_fmt;
  logic [W-1:0]     in_data;
  logic             out_valid, out_ready;
  logic [W-1:0]     out_data;
  logic [LANES-1:0] out_nan, out_inf, out_sub;

  typedef struct {
    logic [W-1:0]     data;
    logic [LANES-1:0] nan;
    logic [LANES-1:0] inf;
    logic [LANES-1:0] sub;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks   = 0;
  int           failures = 0;
  bit           bp_mode  = 1'b0;
  bit           saw_stall = 1'b0;
  bit           hold_armed = 1'b0;
  logic [W-1:0] held_data;
  logic [3:0]   bp_pat = 4'b1001;  // bit i = out_ready on cycle i mod 4
  int           cyc = 0;

  fp16_to_fp32_pipe #(.PARM_XLEN(XLEN), .PARM_LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nan   (out_nan),
    .out_inf   (out_inf),
    .out_sub   (out_sub)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // Behavioural reference: subnormals normalised by an explicit shift loop.
  function automatic exp_t model(input logic [1:0] fmt, input logic [W-1:0] d);
    exp_t        e;
    logic [31:0] lane, r;
    logic        sg;
    logic [4:0]  ex5;
    logic [9:0]  m;
    logic [10:0] mm;
    int          ex;
    e.data = '0; e.nan = '0; e.inf = '0; e.sub = '0;
    for (int k = 0; k < LANES; k++) begin
      lane = d[k*XLEN +: XLEN];
      sg = lane[15]; ex5 = lane[14:10]; m = lane[9:0];
      if (fmt == 2'b01) begin
        if (ex5 == 5'd31) begin
          if (m == 10'd0) begin
            r = {sg, 8'hFF, 23'd0}; e.inf[k] = 1'b1;
          end else begin
            r = {sg, 8'hFF, 1'b1, m[8:0], 13'd0}; e.nan[k] = 1'b1;
          end
        end else if (ex5 == 5'd0 && m == 10'd0) begin
          r = {sg, 31'd0};
        end else if (ex5 == 5'd0) begin
          ex = -14; mm = {1'b0, m};
          while (!mm[10]) begin
            mm = mm << 1; ex--;
          end
          r = {sg, 8'(ex + 127), mm[9:0], 13'd0};
          e.sub[k] = 1'b1;
        end else begin
          r = {sg, 8'(int'(ex5) - 15 + 127), m, 13'd0};
        end
      end else if (fmt == 2'b10) begin
        r = {lane[15:0], 16'd0};
        if (lane[14:7] == 8'hFF) begin
          if (lane[6:0] != 7'd0) begin
            r[22] = 1'b1; e.nan[k] = 1'b1;
          end else begin
            e.inf[k] = 1'b1;
          end
        end
      end else begin
        r = lane;
      end
      e.data[k*XLEN +: XLEN] = r;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Drive one transaction; the expected entry is pushed on the accepting edge.
  task automatic send_x(input logic [1:0] fmt, input logic [W-1:0] data, input exp_t e);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    @(negedge clk);
    in_valid = 1'b1; in_fmt = fmt; in_data = data;
    while (!acc && tries < 100) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) sb.push_back(e);
      else begin
        tries++;
        @(negedge clk);
      end
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic send(input logic [1:0] fmt, input logic [W-1:0] data);
    send_x(fmt, data, model(fmt, data));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; in_fmt = 2'b00; in_data = '0; out_ready = 1'b1;

    fork
      forever begin
        @(posedge clk);
        #1;
        cyc++;
        out_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
      end
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hold_armed = 1'b0;
        end else begin
          if (hold_armed) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, held_data);
          end
          if (out_valid && out_ready) begin
            hold_armed = 1'b0;
            if (sb.size() == 0) begin
              check("unexpected_output", 1, 0);
            end else begin
              mon_e = sb.pop_front();
              check("out_data", out_data, mon_e.data);
              check("out_nan", out_nan, mon_e.nan);
              check("out_inf", out_inf, mon_e.inf);
              check("out_sub", out_sub, mon_e.sub);
            end
          end else if (out_valid) begin
            hold_armed = 1'b1;
            held_data  = out_data;
          end else begin
            hold_armed = 1'b0;
          end
          if (!in_ready) begin
            saw_stall = 1'b1;
            check("stall_only_when_out_blocked", out_valid && !out_ready, 1);
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_nan, out_inf, out_sub}, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // FP16 normals/subnormals, with a latency check on the first transfer
    e.data = pack4(32'h3F800000, 32'h33800000, 32'h387FC000, 32'hC0000000);
    e.nan = 4'b0000; e.inf = 4'b0000; e.sub = 4'b0110;
    send_x(2'b01, pack4(32'h3C00, 32'h0001, 32'h03FF, 32'hC000), e);
    @(negedge clk);
    in_valid = 1'b0;
    check("latency_cycle1", out_valid, 0);
    @(negedge clk);
    check("latency_cycle2", out_valid, 1);

    // FP16 specials
    e.data = pack4(32'h7F800000, 32'hFF800000, 32'h7FC02000, 32'h80000000);
    e.nan = 4'b0100; e.inf = 4'b0011; e.sub = 4'b0000;
    send_x(2'b01, pack4(32'h7C00, 32'hFC00, 32'h7C01, 32'h8000), e);
    // BF16 normal, NaN quieting, infinity; upper lane bits are garbage
    e.data = pack4(32'h3F800000, 32'h7FC10000, 32'h7F800000, 32'h00000000);
    e.nan = 4'b0010; e.inf = 4'b0100; e.sub = 4'b0000;
    send_x(2'b10, pack4(32'hABCD3F80, 32'h00007F81, 32'hFFFF7F80, 32'h55550000), e);
    // Pass-through and reserved code
    e.data = pack4(32'h12345678, 32'h7F800001, 32'hFFFFFFFF, 32'h00007C01);
    e.nan = 4'b0000; e.inf = 4'b0000; e.sub = 4'b0000;
    send_x(2'b00, e.data, e);
    send_x(2'b11, e.data, e);
    // FP16 with upper bits set: must be ignored
    e.data = pack4(32'h3F800000, 32'h33800000, 32'h387FC000, 32'hC0000000);
    e.nan = 4'b0000; e.inf = 4'b0000; e.sub = 4'b0110;
    send_x(2'b01, pack4(32'hFFFF3C00, 32'h12340001, 32'h800003FF, 32'h0001C000), e);

    // Random mixed formats, back to back
    for (int i = 0; i < 16; i++)
      send(2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom});
    idle();
    drain("drain_directed_random");

    // Back-pressure: 8 back-to-back transactions, out_ready = 1,0,0,1,...
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++)
      send(2'b01, pack4(32'h3C00 + i, 32'h0100 + i, 32'hBC00 + i, 32'h7C00 + i));
    idle();
    drain("drain_backpressure");
    bp_mode = 1'b0;
    check("bp_stall_seen", saw_stall, 1);

    // Reset with two transactions in flight
    repeat (2) @(negedge clk);
    send(2'b01, pack4(32'h3C00, 32'h4000, 32'h4200, 32'h4400));
    send(2'b10, pack4(32'h3F80, 32'h4000, 32'h4040, 32'h4080));
    #1;
    check("pre_rst_out_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", out_data, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Pipeline still works after reset
    send(2'b01, pack4(32'h0200, 32'h8001, 32'h7BFF, 32'h0400));
    idle();
    drain("drain_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp16_to_fp32_pipe.md
Name: fp16_to_fp32_pipe

Overview:
- Multi-lane, pipelined converter that widens FP16 or BF16 operands to FP32 ahead of the MAC datapath.
- Supports a pass-through mode for operands that are already 32-bit.
- Adds over the combinational converter: valid/ready flow control, a 2-stage pipeline with back-pressure, LANES-wide parallel conversion, BF16 support, and per-lane class flags.

Parameters:
- PARM_XLEN, 32, lane width in bits; the converted result always occupies the full lane.
- PARM_LANES, 4, number of independent conversion lanes per transaction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  converter can accept an input this cycle.
- in_fmt  in  2  format code: 00 pass-through, 01 FP16, 10 BF16, 11 reserved (treated as pass-through).
- in_data  in  PARM_LANES*PARM_XLEN  packed lanes; lane k is bits [k*PARM_XLEN +: PARM_XLEN]; FP16/BF16 modes use the lane's low 16 bits.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  PARM_LANES*PARM_XLEN  converted FP32 lanes, same packing as in_data.
- out_nan  out  PARM_LANES  per-lane flag: source was NaN (FP16/BF16 modes only, else 0).
- out_inf  out  PARM_LANES  per-lane flag: source was infinity.
- out_sub  out  PARM_LANES  per-lane flag: source was a nonzero FP16 subnormal.

Behaviour:
- Reset (asynchronous on rst_n low): out_valid=0, s1_valid=0; out_data, out_nan, out_inf and out_sub all 0. in_ready=1 after reset.
- Handshake:
  - A transfer occurs on a cycle with valid && ready.
  - in_data and in_fmt are sampled only on an input transfer.
  - out_* hold stable while out_valid && !out_ready.
- Pipeline: stage 1 (S1) registers classification and LZC results; stage 2 (S2) registers the assembled outputs.
  - Latency: 2 cycles from input transfer to out_valid with out_ready held high.
  - Throughput: 1 transaction per cycle.
  - adv = !out_valid || out_ready.
  - in_ready = !s1_valid || adv. This is combinational and carries no dependence on in_valid.
  - S1 moves to S2 when s1_valid && adv.
  - S2 clears when out_ready is high and no S1 data is advancing.
  - No transaction is ever dropped or duplicated under any out_ready pattern.
- S1 per lane, FP16 mode, h = lane[15:0], e = h[14:10], m = h[9:0]:
  - Classify: zero (e==0, m==0), sub (e==0, m!=0), inf (e==31, m==0), nan (e==31, m!=0), else normal.
  - Compute p, the index of the leading 1 in m (9..0), with shift = 10-p.
- S2 per lane, FP16 mode:
  - zero: {s, 31'b0}.
  - normal: {s, e+112 (8 bits), m, 13'b0}.
  - sub: {s, 113-shift, (m<<shift)[9:0], 13'b0}.
  - inf: {s, 8'hFF, 23'b0}.
  - nan: {s, 8'hFF, 1'b1, m[8:0], 13'b0}. The payload is preserved and the result is forced quiet.
- BF16 mode: result = {lane[15:0], 16'b0}.
  - NaN sources are forced quiet by setting bit 22.
  - nan/inf flags come from lane[14:7]==8'hFF; out_sub=0.
- Pass-through mode: result = lane unchanged; all flags 0.
- Upper lane bits [PARM_XLEN-1:16] are ignored in FP16/BF16 modes.
- Reset mid-operation discards all in-flight transactions.
- Simultaneous in and out transfers on a full pipeline are legal and keep full throughput.

Decomposition:
- Package fp_conv_pkg holds:
  - fmt_e enum (FMT_PASS, FMT_FP16, FMT_BF16);
  - the constants FP16_BIAS_ADJ=112, FP32_QNAN_BIT=22, FP16_EXP_MAX=5'h1F and FP32_EXP_MAX=8'hFF;
  - a packed s1 lane struct (sign, class, exp, mant, shift).
- One sub-module, fp_lzc10: a combinational 10-bit leading-zero counter that returns shift (1..10). It is instantiated once per lane.

Test Plan:
- FP16, lanes {0x3C00, 0x0001, 0x03FF, 0xC000} -> {0x3F800000, 0x33800000, 0x387FC000, 0xC0000000} after 2 cycles; out_sub=4'b0110.
- FP16, lanes {0x7C00, 0xFC00, 0x7C01, 0x8000} -> {0x7F800000, 0xFF800000, 0x7FC02000, 0x80000000}; out_inf=4'b0011, out_nan=4'b0100.
- BF16 0x3F80 -> 0x3F800000; BF16 0x7F81 -> 0x7FC10000 with nan=1. Pass 0x12345678 -> 0x12345678 with all flags 0.
- Back-pressure:
  - Stimulus: 8 back-to-back transactions with an incrementing payload, while out_ready toggles with pattern 1,0,0,1,...
  - Required: the output order and values match the input; in_ready deasserts while both stages are full; no loss or duplication.
- Assert rst_n low while 2 transactions are in flight -> out_valid=0 immediately; no stale output appears after release; in_ready=1.
